// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory arbiter: arbiter states, owner IDs
// and the {valid, owner} tag carried alongside each outstanding read.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_owner_tag_pipe.sv
// owner_tag_pipe: DEPTH-deep shift register of read tags with synchronous
// clear. The tail entry lines up with the memory's read-data return.
module owner_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic clr_i,
  input  tag_t push_i,
  output tag_t tail_o
);

  tag_t pipe_q [DEPTH];

  // Shift one stage per cycle; clear drops every outstanding tag
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push_i;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared main memory to the icache or dcache and
// routes returning read words back by a latency-matched owner tag pipe.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties in IDLE go to the client not granted
// last; without it the dcache always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ren,
  input  logic          i_wen,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_data_valid,
  input  logic          d_ren,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_data_valid,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_data_valid
);

  localparam int unsigned QW = $clog2(MEM_LAT + 1);

  arb_state_e    state_q, state_d, tie_st;
  logic          i_req, d_req;
  logic          owner;
  logic          own_ren, own_wen;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  tag_t          push, tail;
  logic [QW-1:0] quiet_q;

  assign i_req = i_ren | i_wen;
  assign d_req = d_ren | d_wen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Track the most recent owner so the next tie goes to the other client
  always_ff @(posedge clk) begin
    if (rst)                   last_q <= OWN_I;
    else if (state_q == GNT_I) last_q <= OWN_I;
    else if (state_q == GNT_D) last_q <= OWN_D;
  end

  assign tie_st = (last_q == OWN_I) ? GNT_D : GNT_I;
`else
  assign tie_st = GNT_D;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and owner-side mux; IDLE leaves every memory output at 0
  always_comb begin
    state_d   = state_q;
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = tie_st;
        else if (d_req)     state_d = GNT_D;
        else if (i_req)     state_d = GNT_I;
      end
      GNT_I: begin
        own_ren   = i_ren;
        own_wen   = i_wen;
        own_addr  = i_addr;
        own_wdata = i_wdata;
        if (!i_req) state_d = d_req ? GNT_D : IDLE;
      end
      GNT_D: begin
        own_ren   = d_ren;
        own_wen   = d_wen;
        own_addr  = d_addr;
        own_wdata = d_wdata;
        if (!d_req) state_d = i_req ? GNT_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner     = (state_q == GNT_D) ? OWN_D : OWN_I;
  assign mem_ren   = own_ren;
  assign mem_wen   = own_wen & ~own_ren;
  assign mem_addr  = own_addr;
  assign mem_wdata = own_wdata;
  assign i_ready   = (state_q == GNT_I);
  assign d_ready   = (state_q == GNT_D);

  assign push.valid = mem_ren;
  assign push.owner = owner;

  owner_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk_i  (clk),
    .clr_i  (rst),
    .push_i (push),
    .tail_o (tail)
  );

  assign i_data_valid = mem_data_valid & tail.valid & (tail.owner == OWN_I);
  assign d_data_valid = mem_data_valid & tail.valid & (tail.owner == OWN_D);
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;

  // Post-reset window: reads issued before reset may still return untagged
  always_ff @(posedge clk) begin
    if (rst)                quiet_q <= QW'(MEM_LAT);
    else if (quiet_q != '0) quiet_q <= quiet_q - QW'(1);
  end

  a_ren_wen_excl: assert property (@(posedge clk) disable iff (rst)
    !(own_ren && own_wen));

  a_no_orphan_data: assert property (@(posedge clk) disable iff (rst)
    !(mem_data_valid && !tail.valid && (quiet_q == '0)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 4;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ren, i_wen, d_ren, d_wen;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_ready, d_ready, i_data_valid, d_data_valid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_ren, mem_wen, mem_data_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MEM_LAT (MEM_LAT),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ren          (i_ren),
    .i_wen          (i_wen),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .i_ready        (i_ready),
    .i_rdata        (i_rdata),
    .i_data_valid   (i_data_valid),
    .d_ren          (d_ren),
    .d_wen          (d_wen),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata),
    .d_data_valid   (d_data_valid),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid)
  );

  // Memory: returns addr ^ 0xA5A5 exactly MEM_LAT cycles after each read; not reset
  logic          lat_v [MEM_LAT];
  logic [AW-1:0] lat_a [MEM_LAT];
  always @(posedge clk) begin
    lat_v[0] <= mem_ren;
    lat_a[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      lat_v[k] <= lat_v[k-1];
      lat_a[k] <= lat_a[k-1];
    end
  end
  assign mem_data_valid = lat_v[MEM_LAT-1];
  assign mem_rdata      = lat_a[MEM_LAT-1] ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address a client presents in cycle c when its first accepted beat is at 'start'
  function automatic logic [31:0] beat_addr(input int base, input int c, input int start);
    int k;
    k = c - start;
    if (k < 0) k = 0;
    if (k > 7) k = 7;
    return 32'(base + 2 * k);
  endfunction

  task automatic idle(input int unsigned n);
    i_ren = 0; i_wen = 0; d_ren = 0; d_wen = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    i_ren = 0; i_wen = 0; d_ren = 0; d_wen = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    repeat (MEM_LAT + 2) next_cycle();

    // Reset state
    @(negedge clk);
    check("rst_iready", i_ready, 0);
    check("rst_dready", d_ready, 0);
    check("rst_idv", i_data_valid, 0);
    check("rst_ddv", d_data_valid, 0);
    check("rst_mren", mem_ren, 0);
    check("rst_mwen", mem_wen, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    next_cycle();
    rst = 1'b0;
    idle(2);

    // Single icache fill: 8 reads 0x0100..0x010E
    for (int c = 0; c < 15; c++) begin
      i_ren  = (c <= 8);
      i_addr = AW'(beat_addr(32'h0100, c, 1));
      @(negedge clk);
      check("fill_iready", i_ready, (c >= 1 && c <= 9));
      check("fill_mren", mem_ren, (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) check("fill_maddr", mem_addr, 32'h0100 + 2 * (c - 1));
      check("fill_idv", i_data_valid, (c >= 5 && c <= 12));
      check("fill_ddv", d_data_valid, 0);
      if (c >= 5 && c <= 12) check("fill_rdata", i_rdata, (32'h0100 + 2 * (c - 5)) ^ 32'hA5A5);
      next_cycle();
    end
    idle(3);

    // Simultaneous request: dcache first, then icache with d reads still in flight
    for (int c = 0; c < 24; c++) begin
      d_ren  = (c <= 8);
      d_addr = AW'(beat_addr(32'h3000, c, 1));
      i_ren  = (c <= 17);
      i_addr = AW'(beat_addr(32'h0200, c, 10));
      @(negedge clk);
      check("sim_dready", d_ready, (c >= 1 && c <= 9));
      check("sim_iready", i_ready, (c >= 10 && c <= 18));
      check("sim_mren", mem_ren, ((c >= 1 && c <= 8) || (c >= 10 && c <= 17)));
      if (c >= 1 && c <= 8)   check("sim_maddr_d", mem_addr, 32'h3000 + 2 * (c - 1));
      if (c >= 10 && c <= 17) check("sim_maddr_i", mem_addr, 32'h0200 + 2 * (c - 10));
      check("ho_ddv", d_data_valid, (c >= 5 && c <= 12));
      check("sim_idv", i_data_valid, (c >= 14 && c <= 21));
      if (c >= 5 && c <= 12)  check("ho_drdata", d_rdata, (32'h3000 + 2 * (c - 5)) ^ 32'hA5A5);
      if (c >= 14 && c <= 21) check("sim_irdata", i_rdata, (32'h0200 + 2 * (c - 14)) ^ 32'hA5A5);
      next_cycle();
    end
    idle(3);

    // dcache write-through 0xBEEF to 0x2000
    for (int c = 0; c < 8; c++) begin
      d_wen   = (c <= 1);
      d_addr  = 16'h2000;
      d_wdata = 16'hBEEF;
      @(negedge clk);
      check("wr_dready", d_ready, (c >= 1 && c <= 2));
      check("wr_mwen", mem_wen, (c == 1));
      check("wr_mren", mem_ren, 0);
      if (c == 1) begin
        check("wr_maddr", mem_addr, 32'h2000);
        check("wr_mwdata", mem_wdata, 32'hBEEF);
      end
      check("wr_idv", i_data_valid, 0);
      check("wr_ddv", d_data_valid, 0);
      next_cycle();
    end
    idle(3);

    // Reset during the 3rd read of an icache burst
    for (int c = 0; c < 10; c++) begin
      i_ren  = (c <= 3);
      i_addr = AW'(beat_addr(32'h0400, c, 1));
      rst    = (c == 3);
      @(negedge clk);
      if (c >= 1 && c <= 3) check("mid_iready", i_ready, 1);
      if (c >= 4) begin
        check("mid_iready0", i_ready, 0);
        check("mid_dready0", d_ready, 0);
        check("mid_mren0", mem_ren, 0);
        check("mid_mwen0", mem_wen, 0);
        check("mid_maddr0", mem_addr, 0);
        check("mid_mwdata0", mem_wdata, 0);
      end
      check("mid_idv", i_data_valid, 0);
      check("mid_ddv", d_data_valid, 0);
      next_cycle();
    end
    rst = 1'b0;
    idle(2);

    // Two consecutive ties in IDLE
    for (int c = 0; c < 10; c++) begin
      i_ren  = (c <= 1) || (c == 4) || (c == 5);
      d_ren  = i_ren;
      i_addr = 16'h0500;
      d_addr = 16'h3500;
      @(negedge clk);
      if (c == 1) begin
        check("tie1_dready", d_ready, 1);
        check("tie1_iready", i_ready, 0);
        check("tie1_maddr", mem_addr, 32'h3500);
      end
      if (c == 4) check("tie2_idle", i_ready | d_ready, 0);
      if (c == 5) begin
        check("tie2_dready", d_ready, !RR);
        check("tie2_iready", i_ready, RR);
        check("tie1_ret_ddv", d_data_valid, 1);
        check("tie1_ret_idv", i_data_valid, 0);
      end
      if (c == 9) begin
        check("tie2_ret_idv", i_data_valid, RR);
        check("tie2_ret_ddv", d_data_valid, !RR);
      end
      next_cycle();
    end
    idle(MEM_LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
